// File: rtl/conv_sequencer.sv
// Convolution sequencer: walks the rj segment table and per-channel coefficient lists,
// driving memory addresses and shift-add accumulator control for left then right channel.
//
// state | meaning
// IDLE  | waiting for work_enable
// INIT  | accumulator clear, per-channel pointers reset
// RJ_LD | read segment length rj[j]
// MAC   | one coefficient per cycle until the segment is exhausted
// SHIFT | accumulator >> 1 at the end of each segment
// OUT   | result valid for ch_sel
module conv_sequencer #(
    parameter int NUM_RJ    = 16,
    parameter int CH_COEFFS = 256
) (
    input  logic       Sclk,
    input  logic       Reset,
    input  logic       Clear,
    input  logic       work_enable,
    input  logic [7:0] n_ptr,
    input  logic [7:0] rj_data,
    input  logic [8:0] coeff_data,
    output logic [3:0] rj_addr,
    output logic [8:0] coeff_addr,
    output logic [7:0] data_addr,
    output logic       ch_sel,
    output logic       acc_clr,
    output logic       acc_en,
    output logic       acc_sub,
    output logic       x_zero,
    output logic       acc_shift,
    output logic       out_valid,
    output logic       busy,
    output logic       overrun,
    output logic       cfg_err
);

    localparam logic [8:0] COEFF_LIM = 9'(CH_COEFFS);
    localparam logic [8:0] R_BASE    = 9'(CH_COEFFS);
    localparam logic [3:0] J_LAST    = 4'(NUM_RJ - 1);

    typedef enum logic [2:0] {IDLE, INIT, RJ_LD, MAC, SHIFT, OUT} state_t;

    state_t     state;
    logic [3:0] j;
    logic [7:0] seg;
    logic [8:0] coeff_ptr;
    logic [8:0] cpc;
    logic [7:0] n_lat;
    logic [8:0] x_lim;
    logic [8:0] sample_cnt;
    logic [7:0] data_addr_q;
    logic [7:0] data_addr_mac;
    logic       mac_next;
    logic       mac_ok;

    // Operand fields follow the combinational coefficient read in the MAC cycle itself.
    assign data_addr_mac = n_lat - coeff_data[7:0];
    assign data_addr     = acc_en ? data_addr_mac : data_addr_q;
    assign acc_sub       = acc_en & coeff_data[8];
    assign x_zero        = acc_en & ({1'b0, coeff_data[7:0]} >= x_lim);

    assign mac_next = ((state == RJ_LD) && (rj_data != 8'd0)) ||
                      ((state == MAC) && (seg != 8'd0));
    assign mac_ok   = (cpc < COEFF_LIM);

    always_ff @(posedge Sclk) begin
        if (Reset || Clear) begin
            state       <= IDLE;
            j           <= 4'd0;
            seg         <= 8'd0;
            coeff_ptr   <= 9'd0;
            cpc         <= 9'd0;
            n_lat       <= 8'd0;
            x_lim       <= 9'd0;
            sample_cnt  <= 9'd0;
            data_addr_q <= 8'd0;
            rj_addr     <= 4'd0;
            coeff_addr  <= 9'd0;
            ch_sel      <= 1'b0;
            acc_clr     <= 1'b0;
            acc_en      <= 1'b0;
            acc_shift   <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            acc_clr   <= 1'b0;
            acc_en    <= 1'b0;
            acc_shift <= 1'b0;
            out_valid <= 1'b0;

            if (work_enable && (sample_cnt != COEFF_LIM))
                sample_cnt <= sample_cnt + 9'd1;
            if (work_enable && busy)
                overrun <= 1'b1;
            if (acc_en)
                data_addr_q <= data_addr_mac;

            case (state)
                IDLE: begin
                    if (work_enable) begin
                        n_lat   <= n_ptr;
                        // the sample arriving now already counts as received
                        x_lim   <= (sample_cnt == COEFF_LIM) ? sample_cnt : sample_cnt + 9'd1;
                        busy    <= 1'b1;
                        ch_sel  <= 1'b0;
                        acc_clr <= 1'b1;
                        state   <= INIT;
                    end
                end
                INIT: begin
                    j         <= 4'd0;
                    rj_addr   <= 4'd0;
                    coeff_ptr <= ch_sel ? R_BASE : 9'd0;
                    cpc       <= 9'd0;
                    state     <= RJ_LD;
                end
                RJ_LD: begin
                    if (rj_data == 8'd0) begin
                        acc_shift <= 1'b1;
                        state     <= SHIFT;
                    end else begin
                        seg   <= rj_data - 8'd1;
                        state <= MAC;
                    end
                end
                MAC: begin
                    if (seg == 8'd0) begin
                        acc_shift <= 1'b1;
                        state     <= SHIFT;
                    end else begin
                        seg <= seg - 8'd1;
                    end
                end
                SHIFT: begin
                    if (j == J_LAST) begin
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        j       <= j + 4'd1;
                        rj_addr <= j + 4'd1;
                        state   <= RJ_LD;
                    end
                end
                OUT: begin
                    if (!ch_sel) begin
                        ch_sel  <= 1'b1;
                        acc_clr <= 1'b1;
                        state   <= INIT;
                    end else begin
                        busy   <= 1'b0;
                        ch_sel <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Coefficients beyond the channel's slot budget are skipped, not wrapped.
            if (mac_next) begin
                if (mac_ok) begin
                    acc_en     <= 1'b1;
                    coeff_addr <= coeff_ptr;
                    coeff_ptr  <= coeff_ptr + 9'd1;
                    cpc        <= cpc + 9'd1;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer with behavioural rj/coeff memories and per-run event statistics.
module tb_conv_sequencer;

    logic       Sclk = 1'b0;
    logic       Reset, Clear, work_enable;
    logic [7:0] n_ptr, rj_data;
    logic [8:0] coeff_data;
    logic [3:0] rj_addr;
    logic [8:0] coeff_addr;
    logic [7:0] data_addr;
    logic       ch_sel, acc_clr, acc_en, acc_sub, x_zero, acc_shift, out_valid, busy, overrun, cfg_err;

    logic [7:0] rj_mem [16];
    logic [8:0] coeff_mem [512];

    int n_checks = 0;
    int n_fail   = 0;

    int n_clr, clr_first, n_ov, excl_err, seq_err, data_err, busy_fall, cmin_r, cmax_r;
    int n_en [2];
    int n_sh [2];
    int ov_cyc [2];
    logic [7:0] exp_da [2];
    logic       exp_sub [2];
    logic       exp_xz [2];
    bit         chk_data;

    conv_sequencer dut (
        .Sclk(Sclk), .Reset(Reset), .Clear(Clear), .work_enable(work_enable),
        .n_ptr(n_ptr), .rj_data(rj_data), .coeff_data(coeff_data),
        .rj_addr(rj_addr), .coeff_addr(coeff_addr), .data_addr(data_addr),
        .ch_sel(ch_sel), .acc_clr(acc_clr), .acc_en(acc_en), .acc_sub(acc_sub),
        .x_zero(x_zero), .acc_shift(acc_shift), .out_valid(out_valid),
        .busy(busy), .overrun(overrun), .cfg_err(cfg_err)
    );

    assign rj_data    = rj_mem[rj_addr];
    assign coeff_data = coeff_mem[coeff_addr];

    always #5 Sclk = ~Sclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_rj_all(input logic [7:0] v);
        for (int i = 0; i < 16; i++) rj_mem[i] = v;
    endtask

    task automatic set_coeffs(input logic [8:0] l, input logic [8:0] r);
        for (int i = 0; i < 256; i++) begin
            coeff_mem[i]       = l;
            coeff_mem[i + 256] = r;
        end
    endtask

    task automatic set_exp(input logic [7:0] da_l, input logic sub_l, input logic xz_l,
                           input logic [7:0] da_r, input logic sub_r, input logic xz_r);
        exp_da[0] = da_l; exp_sub[0] = sub_l; exp_xz[0] = xz_l;
        exp_da[1] = da_r; exp_sub[1] = sub_r; exp_xz[1] = xz_r;
        chk_data  = 1'b1;
    endtask

    task automatic run(input logic [7:0] np, input int ovr_at, input int clr_at, input int max_cyc);
        int exp_ca;
        n_clr = 0; clr_first = 0; n_ov = 0; excl_err = 0; seq_err = 0; data_err = 0;
        busy_fall = 0; cmin_r = 100000; cmax_r = -1;
        for (int c = 0; c < 2; c++) begin n_en[c] = 0; n_sh[c] = 0; ov_cyc[c] = 0; end
        work_enable = 1'b1;
        n_ptr       = np;
        @(posedge Sclk); #1;
        work_enable = 1'b0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            if (!busy) begin
                busy_fall = cyc;
                break;
            end
            if (int'(acc_clr) + int'(acc_en) + int'(acc_shift) + int'(out_valid) > 1) excl_err++;
            if (acc_clr) begin
                n_clr++;
                if (clr_first == 0) clr_first = cyc;
            end
            if (acc_shift) n_sh[ch_sel]++;
            if (out_valid) begin
                n_ov++;
                ov_cyc[ch_sel] = cyc;
            end
            if (acc_en) begin
                exp_ca = (ch_sel ? 256 : 0) + n_en[ch_sel];
                if (int'(coeff_addr) != exp_ca) seq_err++;
                if (ch_sel) begin
                    if (int'(coeff_addr) < cmin_r) cmin_r = int'(coeff_addr);
                    if (int'(coeff_addr) > cmax_r) cmax_r = int'(coeff_addr);
                end
                if (chk_data && (data_addr !== exp_da[ch_sel] || acc_sub !== exp_sub[ch_sel] ||
                                 x_zero !== exp_xz[ch_sel]))
                    data_err++;
                n_en[ch_sel]++;
            end
            if (cyc == ovr_at) work_enable = 1'b1;
            if (cyc == clr_at) Clear = 1'b1;
            @(posedge Sclk); #1;
            work_enable = 1'b0;
            if (Clear) begin
                chk("clr_busy", {31'd0, busy}, 32'd0);
                chk("clr_strobes", {28'd0, acc_clr, acc_en, acc_shift, out_valid}, 32'd0);
                chk("clr_outs", {11'd0, rj_addr, coeff_addr, data_addr, ch_sel}, 32'd0);
                chk("clr_overrun", {31'd0, overrun}, 32'd0);
                chk("clr_sample_cnt", {23'd0, dut.sample_cnt}, 32'd0);
                Clear = 1'b0;
                break;
            end
        end
    endtask

    task automatic check_run(input string pfx, input int en_exp, input int ovl, input int ovr);
        chk({pfx, "_clr_first"}, clr_first, 1);
        chk({pfx, "_n_clr"}, n_clr, 2);
        chk({pfx, "_en_l"}, n_en[0], en_exp);
        chk({pfx, "_en_r"}, n_en[1], en_exp);
        chk({pfx, "_sh_l"}, n_sh[0], 16);
        chk({pfx, "_sh_r"}, n_sh[1], 16);
        chk({pfx, "_ov_l"}, ov_cyc[0], ovl);
        chk({pfx, "_ov_r"}, ov_cyc[1], ovr);
        chk({pfx, "_n_ov"}, n_ov, 2);
        chk({pfx, "_busy_fall"}, busy_fall, ovr + 1);
        chk({pfx, "_excl"}, excl_err, 0);
        chk({pfx, "_coeff_seq"}, seq_err, 0);
        chk({pfx, "_data"}, data_err, 0);
        chk({pfx, "_idle_strobes"}, {28'd0, acc_clr, acc_en, acc_shift, out_valid}, 32'd0);
    endtask

    initial begin
        int quiet;
        Reset = 1'b1; Clear = 1'b0; work_enable = 1'b0; n_ptr = 8'd0; chk_data = 1'b0;
        set_rj_all(8'd16);
        set_coeffs({1'b0, 8'd3}, {1'b1, 8'd3});
        repeat (3) @(posedge Sclk);
        #1;
        chk("rst_outs", {1'b0, rj_addr, coeff_addr, data_addr, ch_sel, acc_clr, acc_en, acc_sub,
                         x_zero, acc_shift, out_valid, busy, overrun, cfg_err}, 32'd0);
        Reset = 1'b0;
        @(posedge Sclk); #1;

        // first sample after reset: k=3 from n=0 wraps to 253, sample not yet received
        set_exp(8'd253, 1'b0, 1'b1, 8'd253, 1'b1, 1'b1);
        run(8'd0, 0, 0, 1000);
        check_run("zpad1", 256, 290, 580);
        chk("zpad1_overrun", {31'd0, overrun}, 32'd0);
        chk("zpad1_cfg_err", {31'd0, cfg_err}, 32'd0);

        set_exp(8'd4, 1'b0, 1'b1, 8'd4, 1'b1, 1'b1);
        run(8'd7, 0, 0, 1000);
        chk("zpad2_data", data_err, 0);

        // basic run: third sample
        set_coeffs({1'b0, 8'd0}, {1'b1, 8'd1});
        set_exp(8'd5, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0);
        run(8'd5, 0, 0, 1000);
        check_run("basic", 256, 290, 580);

        // fourth sample: k=3 now refers to a received sample
        set_coeffs({1'b0, 8'd3}, {1'b1, 8'd3});
        set_exp(8'd253, 1'b0, 1'b0, 8'd253, 1'b1, 1'b0);
        run(8'd0, 0, 0, 1000);
        chk("zpad4_data", data_err, 0);
        chk("zpad4_en_l", n_en[0], 256);

        // empty segments mixed with full ones
        set_rj_all(8'd0);
        rj_mem[1] = 8'd200;
        rj_mem[3] = 8'd56;
        set_coeffs({1'b0, 8'd0}, {1'b1, 8'd1});
        set_exp(8'd9, 1'b0, 1'b0, 8'd8, 1'b1, 1'b0);
        run(8'd9, 0, 0, 1000);
        check_run("empty", 256, 290, 580);

        // rj sum 272 per channel overruns the 256 coefficient slots
        set_rj_all(8'd17);
        chk_data = 1'b0;
        run(8'd1, 0, 0, 1000);
        check_run("ovfl", 256, 306, 612);
        chk("ovfl_cfg_err", {31'd0, cfg_err}, 32'd1);
        chk("ovfl_r_min", cmin_r, 256);
        chk("ovfl_r_max", cmax_r, 511);

        Reset = 1'b1;
        @(posedge Sclk); #1;
        Reset = 1'b0;
        chk("rst2_cfg_err", {31'd0, cfg_err}, 32'd0);

        // overrun: first sample after reset, so R k=1 is still zero padding
        set_rj_all(8'd16);
        set_exp(8'd5, 1'b0, 1'b0, 8'd4, 1'b1, 1'b1);
        run(8'd5, 100, 0, 1000);
        check_run("ovrn", 256, 290, 580);
        chk("ovrn_overrun", {31'd0, overrun}, 32'd1);

        chk_data = 1'b0;
        run(8'd5, 0, 150, 1000);
        chk("clr_no_outvalid", n_ov, 0);
        quiet = 0;
        for (int i = 0; i < 700; i++) begin
            if (out_valid || acc_en || busy || acc_clr) quiet++;
            @(posedge Sclk); #1;
        end
        chk("clr_quiet_after", quiet, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
